// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the program counter, addresses the instruction ROM and
// registers the returned word into the instruction register handed to decode.
module inst_fetch_unit #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    INST_WIDTH = 10,
    parameter int                    JUMP_WIDTH = 6,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Stall,
    input  logic                  JumpEn,
    input  logic [JUMP_WIDTH-1:0] JumpTarget,
    input  logic                  SkipEn,
    output logic [ADDR_WIDTH-1:0] InstAddress,
    input  logic [INST_WIDTH-1:0] InstIn,
    output logic [INST_WIDTH-1:0] InstOut,
    output logic                  InstValid,
    output logic [ADDR_WIDTH-1:0] PCOut,
    output logic                  Halted
);

    localparam int         OP_WIDTH = 4;
    localparam logic [3:0] OP_HALT  = 4'b0000;

    typedef enum logic {
        RUN,
        HALT
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [INST_WIDTH-1:0]   ir_q, ir_d;
    logic                    valid_q, valid_d;
    logic [ADDR_WIDTH-1:0]   pcout_q, pcout_d;
    logic                    halted_q, halted_d;

    logic                    halt_hit;
    logic [ADDR_WIDTH-1:0]   pc_inc;
    logic [ADDR_WIDTH-1:0]   jump_pc;

    // A halt only counts once it is a real (non-bubble) word sitting in the IR.
    assign halt_hit = valid_q && (ir_q[INST_WIDTH-1 -: OP_WIDTH] == OP_HALT);
    assign pc_inc   = pc_q + ADDR_WIDTH'(1);
    assign jump_pc  = ADDR_WIDTH'(JumpTarget);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        valid_d  = valid_q;
        pcout_d  = pcout_q;
        halted_d = halted_q;

        case (state_q)
            RUN: begin
                // Redirect inputs are only looked at on non-stalled cycles;
                // execute re-presents them once the stall drops.
                if (!Stall) begin
                    if (halt_hit) begin
                        state_d  = HALT;
                        halted_d = 1'b1;
                        valid_d  = 1'b0;
                    end else if (JumpEn) begin
                        pc_d    = jump_pc;
                        valid_d = 1'b0;
                    end else if (SkipEn) begin
                        // Word currently on the ROM bus is the one being skipped.
                        pc_d    = pc_inc;
                        valid_d = 1'b0;
                    end else begin
                        ir_d    = InstIn;
                        pcout_d = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_inc;
                    end
                end
            end
            HALT: begin
                valid_d  = 1'b0;
                halted_d = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            valid_q  <= 1'b0;
            pcout_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            valid_q  <= valid_d;
            pcout_q  <= pcout_d;
            halted_q <= halted_d;
        end
    end

    assign InstAddress = pc_q;
    assign InstOut     = ir_q;
    assign InstValid   = valid_q;
    assign PCOut       = pcout_q;
    assign Halted      = halted_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios followed by a
// randomized run, all compared against a small architectural model.
module tb_inst_fetch_unit;

    logic       Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic       Reset, Stall, JumpEn, SkipEn;
    logic [5:0] JumpTarget;
    logic [7:0] InstAddress, PCOut;
    logic [9:0] InstIn, InstOut;
    logic       InstValid, Halted;

    logic       Reset2;
    logic [7:0] InstAddress2, PCOut2;
    logic [9:0] InstIn2, InstOut2;
    logic       InstValid2, Halted2;

    logic [9:0] rom  [256];
    logic [9:0] rom2 [256];

    assign InstIn  = rom[InstAddress];
    assign InstIn2 = rom2[InstAddress2];

    inst_fetch_unit dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .JumpEn(JumpEn),
        .JumpTarget(JumpTarget), .SkipEn(SkipEn), .InstAddress(InstAddress),
        .InstIn(InstIn), .InstOut(InstOut), .InstValid(InstValid),
        .PCOut(PCOut), .Halted(Halted)
    );

    inst_fetch_unit #(.RESET_PC(8'd254)) dut_wrap (
        .Clk(Clk), .Reset(Reset2), .Stall(1'b0), .JumpEn(1'b0),
        .JumpTarget(6'd0), .SkipEn(1'b0), .InstAddress(InstAddress2),
        .InstIn(InstIn2), .InstOut(InstOut2), .InstValid(InstValid2),
        .PCOut(PCOut2), .Halted(Halted2)
    );

    // Architectural model of the fetch stage.
    int         m_pc;
    logic [9:0] m_ir;
    logic       m_valid;
    int         m_pcout;
    logic       m_halted;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".addr"},   32'(InstAddress), 32'(m_pc));
        check({tag, ".inst"},   32'(InstOut),     32'(m_ir));
        check({tag, ".valid"},  32'(InstValid),   32'(m_valid));
        check({tag, ".pcout"},  32'(PCOut),       32'(m_pcout));
        check({tag, ".halted"}, 32'(Halted),      32'(m_halted));
        $display("cyc t=%0t rst=%0b stl=%0b jmp=%0b/%0d skp=%0b -> addr=%0d ir=%b v=%0b pcout=%0d h=%0b",
                 $time, Reset, Stall, JumpEn, JumpTarget, SkipEn,
                 InstAddress, InstOut, InstValid, PCOut, Halted);
    endtask

    // Advance one clock: predict from the inputs as seen at the edge, then compare.
    task automatic cycle(input string tag);
        int         n_pc     = m_pc;
        logic [9:0] n_ir     = m_ir;
        logic       n_valid  = m_valid;
        int         n_pcout  = m_pcout;
        logic       n_halted = m_halted;
        logic [3:0] opcode   = m_ir[9:6];
        if (Reset) begin
            n_pc = 0; n_ir = '0; n_valid = 1'b0; n_pcout = 0; n_halted = 1'b0;
        end else if (!m_halted && !Stall) begin
            if (m_valid && opcode == 4'd0) begin
                n_halted = 1'b1;
                n_valid  = 1'b0;
            end else if (JumpEn) begin
                n_pc    = int'(JumpTarget);
                n_valid = 1'b0;
            end else if (SkipEn) begin
                n_pc    = (m_pc + 1) % 256;
                n_valid = 1'b0;
            end else begin
                n_ir    = rom[m_pc];
                n_pcout = m_pc;
                n_valid = 1'b1;
                n_pc    = (m_pc + 1) % 256;
            end
        end
        @(posedge Clk);
        #1;
        m_pc = n_pc; m_ir = n_ir; m_valid = n_valid; m_pcout = n_pcout; m_halted = n_halted;
        check_all(tag);
    endtask

    initial begin
        int         snap_pc;
        int         snap_pcout;
        int         halt_cycles;
        logic [3:0] op;

        Reset = 1'b1; Stall = 1'b0; JumpEn = 1'b0; SkipEn = 1'b0; JumpTarget = '0;
        Reset2 = 1'b1;
        m_pc = 0; m_ir = '0; m_valid = 1'b0; m_pcout = 0; m_halted = 1'b0;

        // Program image: only address 25 carries the halt opcode.
        for (int i = 0; i < 256; i++) begin
            op      = 4'($urandom_range(1, 15));
            rom[i]  = {op, 6'($urandom)};
            op      = 4'($urandom_range(1, 15));
            rom2[i] = {op, 6'($urandom)};
        end
        rom[0]  = 10'b0100111111;
        rom[22] = 10'b0100010101;
        rom[25] = 10'b0000010111;

        // Reset state and first fetch.
        cycle("reset");
        check("reset_addr", 32'(InstAddress), 32'd0);
        Reset = 1'b0;
        cycle("fetch0");
        check("fetch0_inst", 32'(InstOut), 32'(10'b0100111111));
        check("fetch0_pcout", 32'(PCOut), 32'd0);
        for (int i = 0; i < 8; i++) cycle("run");
        check("pcout8", 32'(PCOut), 32'd8);

        // Jump from 8 to 22 costs one bubble.
        JumpEn = 1'b1; JumpTarget = 6'd22;
        cycle("jump22");
        JumpEn = 1'b0;
        check("jump_bubble", 32'(InstValid), 32'd0);
        check("jump_addr", 32'(InstAddress), 32'd22);
        cycle("after_jump");
        check("jump_pcout", 32'(PCOut), 32'd22);
        check("jump_inst", 32'(InstOut), 32'(10'b0100010101));

        // Return to 9 and run to 11, then skip address 12.
        JumpEn = 1'b1; JumpTarget = 6'd9;
        cycle("jump9");
        JumpEn = 1'b0;
        for (int i = 0; i < 3; i++) cycle("run");
        check("pcout11", 32'(PCOut), 32'd11);
        SkipEn = 1'b1;
        cycle("skip");
        SkipEn = 1'b0;
        check("skip_bubble", 32'(InstValid), 32'd0);
        cycle("after_skip");
        check("skip_pcout", 32'(PCOut), 32'd13);
        check("skip_valid", 32'(InstValid), 32'd1);

        // Jump and skip together: jump wins.
        JumpEn = 1'b1; SkipEn = 1'b1; JumpTarget = 6'd20;
        cycle("jump_skip");
        JumpEn = 1'b0; SkipEn = 1'b0;
        check("js_addr", 32'(InstAddress), 32'd20);
        cycle("after_js");
        check("js_pcout", 32'(PCOut), 32'd20);

        // Run into the halt word at 25 and stay frozen.
        for (int i = 0; i < 5; i++) cycle("run");
        check("halt_word_pcout", 32'(PCOut), 32'd25);
        cycle("halt_detect");
        check("halted", 32'(Halted), 32'd1);
        check("halt_valid", 32'(InstValid), 32'd0);
        for (int i = 0; i < 20; i++) begin
            JumpEn = 1'($urandom); SkipEn = 1'($urandom); Stall = 1'($urandom);
            JumpTarget = 6'($urandom);
            cycle("halt_hold");
            check("halt_addr", 32'(InstAddress), 32'd26);
        end
        JumpEn = 1'b0; SkipEn = 1'b0; Stall = 1'b0;
        Reset = 1'b1;
        cycle("halt_reset");
        Reset = 1'b0;
        check("unhalt_addr", 32'(InstAddress), 32'd0);
        check("unhalt_flag", 32'(Halted), 32'd0);

        // Three-cycle stall with a jump pulse that must be ignored.
        for (int i = 0; i < 4; i++) cycle("run");
        snap_pc = m_pc; snap_pcout = m_pcout;
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            JumpEn = (i == 1); JumpTarget = 6'd40;
            cycle("stall");
            check("stall_addr", 32'(InstAddress), 32'(snap_pc));
            check("stall_pcout", 32'(PCOut), 32'(snap_pcout));
        end
        Stall = 1'b0; JumpEn = 1'b0;
        cycle("resume");
        check("resume_pcout", 32'(PCOut), 32'(snap_pc));

        // Reset wins over a stall with a pending redirect.
        Stall = 1'b1; JumpEn = 1'b1; JumpTarget = 6'd33; Reset = 1'b1;
        cycle("reset_in_stall");
        Stall = 1'b0; JumpEn = 1'b0; Reset = 1'b0;
        check("rst_stall_addr", 32'(InstAddress), 32'd0);

        // Randomized traffic; escape long halts with a reset.
        halt_cycles = 0;
        for (int i = 0; i < 400; i++) begin
            Reset      = ($urandom_range(0, 99) < 2) || (halt_cycles > 25);
            Stall      = ($urandom_range(0, 3) == 0);
            JumpEn     = ($urandom_range(0, 9) == 0);
            SkipEn     = ($urandom_range(0, 9) == 0);
            JumpTarget = 6'($urandom);
            cycle("random");
            halt_cycles = m_halted ? halt_cycles + 1 : 0;
        end
        Reset = 1'b0; Stall = 1'b0; JumpEn = 1'b0; SkipEn = 1'b0;

        // Second instance: reset PC near the top of the address space wraps to 0.
        check("wrap_reset_addr", 32'(InstAddress2), 32'd254);
        Reset2 = 1'b0;
        cycle("wrap0");
        check("wrap_pcout254", 32'(PCOut2), 32'd254);
        check("wrap_inst254", 32'(InstOut2), 32'(rom2[254]));
        check("wrap_valid", 32'(InstValid2), 32'd1);
        cycle("wrap1");
        check("wrap_pcout255", 32'(PCOut2), 32'd255);
        check("wrap_addr0", 32'(InstAddress2), 32'd0);
        cycle("wrap2");
        check("wrap_pcout0", 32'(PCOut2), 32'd0);
        check("wrap_halted", 32'(Halted2), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
